// File: rtl/bench_cond_sequencer.sv
//==============================================================================
// Module   : bench_cond_sequencer
// Purpose  : Operation sequencer and timing collector for the router
//            benchmark. On start_i it walks conditions 0..4 and issues OPS
//            operations per condition over a valid/ready port. It counts the
//            returned responses, times each condition, and then picks the
//            fastest condition with a 5-cycle sequential minimum search.
// Ports    : clk, rst (synchronous, active high), start_i (one-cycle pulse)
//            op_valid_o/op_ready_i/op_cond_o/op_seq_o : operation port
//            resp_valid_i                              : one response per cycle
//            t_cond0_o..t_cond4_o, t_total_o, t_runtime_o : timing results
//            ops_per_condition_o (constant OPS), done_o (one-cycle pulse)
//            winner_code_o, led_onehot_o               : winner report
// Config   : BENCH_SEQ_TIMEOUT_EN enables a per-condition response watchdog
//            (parameter TIMEOUT). Without it, a missing response hangs the
//            sequencer in DRAIN until rst.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module bench_cond_sequencer #(
    parameter logic [15:0] OPS     = 16'd1000,
    parameter int          MAX_OUT = 4
`ifdef BENCH_SEQ_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT = 32'd65535
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    output logic        op_valid_o,
    input  logic        op_ready_i,
    output logic [2:0]  op_cond_o,
    output logic [15:0] op_seq_o,
    input  logic        resp_valid_i,
    output logic [31:0] t_cond0_o,
    output logic [31:0] t_cond1_o,
    output logic [31:0] t_cond2_o,
    output logic [31:0] t_cond3_o,
    output logic [31:0] t_cond4_o,
    output logic [31:0] t_total_o,
    output logic [31:0] t_runtime_o,
    output logic [15:0] ops_per_condition_o,
    output logic        done_o,
    output logic [2:0]  winner_code_o,
    output logic [4:0]  led_onehot_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_SCORE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [2:0]  state_q,   state_d;
    logic [2:0]  cond_q,    cond_d;
    logic [15:0] seq_q,     seq_d;
    logic [3:0]  out_q,     out_d;
    logic [15:0] rcnt_q,    rcnt_d;
    logic [31:0] timer_q,   timer_d;
    logic [31:0] runtime_q, runtime_d;
    logic [31:0] t_cond_q [5];
    logic [31:0] t_cond_d [5];
    logic [31:0] total_q,   total_d;
    logic        err_q,     err_d;
    logic [2:0]  sidx_q,    sidx_d;
    logic [31:0] best_q,    best_d;
    logic [2:0]  bidx_q,    bidx_d;
    logic [2:0]  winner_q,  winner_d;
    logic [4:0]  led_q,     led_d;
    logic        valid_q,   valid_d;
    logic        done_q,    done_d;
`ifdef BENCH_SEQ_TIMEOUT_EN
    logic [31:0] wd_q,      wd_d;
`endif

    logic hs;
    logic resp_ok;

    always_comb begin
        state_d   = state_q;
        cond_d    = cond_q;
        seq_d     = seq_q;
        out_d     = out_q;
        rcnt_d    = rcnt_q;
        timer_d   = timer_q;
        runtime_d = runtime_q;
        t_cond_d  = t_cond_q;
        total_d   = total_q;
        err_d     = err_q;
        sidx_d    = sidx_q;
        best_d    = best_q;
        bidx_d    = bidx_q;
        winner_d  = winner_q;
        led_d     = led_q;
        hs        = 1'b0;
        resp_ok   = 1'b0;
`ifdef BENCH_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
`endif

        // A response with nothing outstanding is a protocol error; it is
        // never counted and poisons the winner report for this run.
        if (resp_valid_i && (out_q == 4'd0) && (state_q != S_IDLE)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_ISSUE;
                    cond_d    = 3'd0;
                    seq_d     = 16'd0;
                    out_d     = 4'd0;
                    rcnt_d    = 16'd0;
                    timer_d   = 32'd0;
                    // The first ISSUE cycle is the first counted runtime cycle.
                    runtime_d = 32'd1;
                    for (int i = 0; i < 5; i++) begin
                        t_cond_d[i] = 32'd0;
                    end
                    total_d   = 32'd0;
                    err_d     = 1'b0;
                    winner_d  = 3'd0;
                    led_d     = 5'd0;
`ifdef BENCH_SEQ_TIMEOUT_EN
                    wd_d      = 32'd0;
`endif
                end
            end

            S_ISSUE, S_DRAIN: begin
                hs      = valid_q && op_ready_i;
                resp_ok = resp_valid_i && (out_q != 4'd0);
                if (hs) begin
                    seq_d = seq_q + 16'd1;
                end
                out_d = out_q + {3'b000, hs} - {3'b000, resp_ok};
                if (resp_ok) begin
                    rcnt_d = rcnt_q + 16'd1;
                end
                // Timer includes the cycle in which the last response lands.
                timer_d = sat_add(timer_q, 32'd1);
                if ((state_q == S_ISSUE) && (seq_d == OPS)) begin
                    state_d = S_DRAIN;
                end
                if (resp_ok && (rcnt_d == OPS)) begin
                    state_d          = S_NEXT;
                    t_cond_d[cond_q] = timer_d;
                end
`ifdef BENCH_SEQ_TIMEOUT_EN
                wd_d = (hs || resp_valid_i) ? 32'd0 : sat_add(wd_q, 32'd1);
                if ((wd_d >= TIMEOUT) && (state_d != S_NEXT)) begin
                    // Abandon whatever is still in flight for this condition.
                    t_cond_d[cond_q] = 32'hFFFF_FFFF;
                    err_d            = 1'b1;
                    out_d            = 4'd0;
                    state_d          = S_NEXT;
                end
`endif
            end

            S_NEXT: begin
                seq_d   = 16'd0;
                rcnt_d  = 16'd0;
                out_d   = 4'd0;
                timer_d = 32'd0;
`ifdef BENCH_SEQ_TIMEOUT_EN
                wd_d    = 32'd0;
`endif
                if (cond_q == 3'd4) begin
                    state_d = S_SCORE;
                    sidx_d  = 3'd0;
                end else begin
                    cond_d  = cond_q + 3'd1;
                    state_d = S_ISSUE;
                end
            end

            S_SCORE: begin
                total_d = sat_add(total_q, t_cond_q[sidx_q]);
                // Strict less-than keeps the lowest index on ties.
                if ((sidx_q == 3'd0) || (t_cond_q[sidx_q] < best_q)) begin
                    best_d = t_cond_q[sidx_q];
                    bidx_d = sidx_q;
                end
                sidx_d = sidx_q + 3'd1;
                // Winner outputs change only once all five times are compared.
                if (sidx_q == 3'd4) begin
                    state_d = S_DONE;
                    if (err_q) begin
                        winner_d = 3'd7;
                        led_d    = 5'b11111;
                    end else begin
                        winner_d = bidx_d;
                        led_d    = 5'b00001 << bidx_d;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Runtime freezes on the DONE cycle (the transition back to IDLE).
        if ((state_q != S_IDLE) && (state_d != S_IDLE)) begin
            runtime_d = sat_add(runtime_q, 32'd1);
        end
    end

    // Registered valid: recomputed from next-state values so it stays high
    // and stable while a stalled offer waits for op_ready_i.
    assign valid_d = (state_d == S_ISSUE) && (seq_d < OPS) && (out_d < 4'(MAX_OUT));
    assign done_d  = (state_d == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cond_q    <= 3'd0;
            seq_q     <= 16'd0;
            out_q     <= 4'd0;
            rcnt_q    <= 16'd0;
            timer_q   <= 32'd0;
            runtime_q <= 32'd0;
            t_cond_q  <= '{default: 32'd0};
            total_q   <= 32'd0;
            err_q     <= 1'b0;
            sidx_q    <= 3'd0;
            best_q    <= 32'd0;
            bidx_q    <= 3'd0;
            winner_q  <= 3'd0;
            led_q     <= 5'd0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef BENCH_SEQ_TIMEOUT_EN
            wd_q      <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cond_q    <= cond_d;
            seq_q     <= seq_d;
            out_q     <= out_d;
            rcnt_q    <= rcnt_d;
            timer_q   <= timer_d;
            runtime_q <= runtime_d;
            t_cond_q  <= t_cond_d;
            total_q   <= total_d;
            err_q     <= err_d;
            sidx_q    <= sidx_d;
            best_q    <= best_d;
            bidx_q    <= bidx_d;
            winner_q  <= winner_d;
            led_q     <= led_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
`ifdef BENCH_SEQ_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign op_valid_o          = valid_q;
    assign op_cond_o           = cond_q;
    assign op_seq_o            = seq_q;
    assign t_cond0_o           = t_cond_q[0];
    assign t_cond1_o           = t_cond_q[1];
    assign t_cond2_o           = t_cond_q[2];
    assign t_cond3_o           = t_cond_q[3];
    assign t_cond4_o           = t_cond_q[4];
    assign t_total_o           = total_q;
    assign t_runtime_o         = runtime_q;
    assign ops_per_condition_o = OPS;
    assign done_o              = done_q;
    assign winner_code_o       = winner_q;
    assign led_onehot_o        = led_q;

endmodule

`default_nettype wire

// File: doc/bench_cond_sequencer.md
# bench_cond_sequencer

Operation sequencer and timing collector for the router benchmark. On `start` it walks conditions 0..4, issuing `OPS` operations per condition over a valid/ready port to the datapath under test and counting returned responses. It records per-condition cycle counts, total and runtime counts, and a winner. It sits directly below the AXI register wrapper, which only consumes its `t_*`, `done`, `winner_code`, `led_onehot` and `ops_per_condition` outputs.

## Interface
- `OPS`, 16'd1000: operations issued per condition; legal range 1..65535.
- `MAX_OUT`, 4: maximum outstanding (issued, not yet responded) operations; legal range 1..15.
- `TIMEOUT`, 32'd65535: watchdog limit in cycles without a response (macro-gated).

- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: single-cycle pulse; begins a run from IDLE.
- `op_valid`  out  1: operation offered.
- `op_ready`  in  1: datapath accepts the operation.
- `op_cond`  out  3: condition index of the offered operation.
- `op_seq`  out  16: sequence number within the condition, 0..OPS-1.
- `resp_valid`  in  1: one response returned this cycle (always accepted).
- `t_cond0..t_cond4`  out  32 each: cycles per condition.
- `t_total`  out  32: saturating sum of `t_cond0..4`.
- `t_runtime`  out  32: cycles from `start` to `done`.
- `ops_per_condition`  out  16: constant `OPS`.
- `done`  out  1: one-cycle pulse at end of run.
- `winner_code`  out  3: index of the minimum `t_cond`.
- `led_onehot`  out  5: one-hot winner; 5'b11111 on error.

## Operation
- States: IDLE → ISSUE → DRAIN → NEXT → (ISSUE | SCORE) → DONE → IDLE.
- IDLE:
  - `start` clears all `t_*`, sets cond=0, seq=0, outstanding=0, runtime=0, then enters ISSUE.
  - `start` in any other state is ignored.
- ISSUE:
  - `op_valid`=1 while seq<OPS and outstanding<MAX_OUT.
  - `op_valid` is held stable, with `op_cond` and `op_seq`, until `op_ready`.
  - On a handshake: seq+1, outstanding+1.
  - On `resp_valid`: outstanding−1, resp_count+1.
  - A handshake and `resp_valid` in the same cycle leave outstanding unchanged.
  - When seq reaches OPS, go to DRAIN.
- DRAIN: wait until resp_count==OPS.
- Condition timer:
  - Starts counting in the first ISSUE cycle of the condition.
  - Stops in the cycle the last response is counted; that cycle is included.
  - The timer value is written to `t_cond[cond]` on entry to NEXT.
- `resp_valid` arriving while outstanding==0 is a protocol error:
  - Ignored for counting.
  - Sets the sticky `err` flag.
- NEXT: cond+1, seq=0, resp_count=0. Return to ISSUE if cond<5, otherwise go to SCORE.
- SCORE:
  - Sequential 5-cycle min search; ties go to the lowest index.
  - `winner_code` = index; `led_onehot` = 1<<index.
  - If `err` is set: `led_onehot`=5'b11111 and `winner_code`=3'd7.
  - `t_total` accumulates with saturation at 32'hFFFFFFFF.
- DONE:
  - `done`=1 for one cycle.
  - `t_runtime` is frozen.
  - Return to IDLE.
  - Results hold until the next `start`.
- `t_runtime` counts every cycle from the cycle after `start` through the DONE cycle, saturating.

## Timing
- Reset values:
  - `op_valid`, `done`: 0.
  - `op_cond`, `op_seq`: 0.
  - All `t_*`: 0.
  - `winner_code`: 0; `led_onehot`: 0.
  - `ops_per_condition`: OPS (constant).
- `op_valid` is registered and first asserted in the cycle after `start`.
- Zero-latency responder with `op_ready`=1:
  - With MAX_OUT≥2, the condition timer equals OPS+1 per condition (issue cycle plus one response cycle overlap).
- Fixed overheads:
  - NEXT: 1 cycle per condition.
  - SCORE: 5 cycles.
  - DONE: 1 cycle.
- `rst` mid-run aborts immediately to IDLE with reset values; no `done` pulse.
- The winner is computed only after all five times are final; outputs never show partial winners.

## Configuration
- `BENCH_SEQ_TIMEOUT_EN` defined:
  - A per-condition watchdog counts cycles since the last handshake or response while in ISSUE/DRAIN.
  - On reaching TIMEOUT: `t_cond[cond]`=32'hFFFFFFFF, `err` is set, pending ops are abandoned, and the sequencer proceeds to NEXT.
- Not defined: no watchdog; a missing response hangs in DRAIN until `rst`.

## Test plan
- OPS=4, MAX_OUT=4, `op_ready`=1, responder latency 1, 3, 2, 5, 4 for conds 0..4:
  - -> `done` pulses once.
  - `winner_code`=0, `led_onehot`=5'b00001.
  - `t_cond0` < `t_cond3`.
  - `t_total` equals the sum of the five times.
- Same setup but cond2 and cond4 given identical minimal latency -> `winner_code`=2 (lowest-index tie-break).
- OPS=8, MAX_OUT=2, latency 10:
  - -> outstanding never exceeds 2 (checked by assertion).
  - Each `t_cond` ≈ 4×(10+1).
  - `op_seq` runs 0..7 in order per condition.
- `op_ready` toggling randomly:
  - -> `op_valid`, `op_cond` and `op_seq` stay stable while stalled.
  - No op is dropped or duplicated; the scoreboard sees exactly OPS ops per condition.
- `rst` asserted during cond 2, then `start` -> all `t_*`=0 after reset; the fresh run completes normally.
- With `BENCH_SEQ_TIMEOUT_EN` and TIMEOUT=100, cond 1 responder silent:
  - -> `t_cond1`=32'hFFFFFFFF.
  - `led_onehot`=5'b11111, `winner_code`=7.
  - `done` still pulses.
